// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and FSM encoding for the register-file write arbiter.
package rf_write_arbiter_pkg;

  // StClear also serves as the one-cycle RUN-pending state when clearing is disabled.
  typedef enum logic [0:0] {
    StClear = 1'b0,
    StRun   = 1'b1
  } state_e;

  localparam logic [4:0] ZeroAddr       = 5'd0;
  localparam logic [4:0] FirstClearAddr = 5'd1;
  localparam logic [4:0] LastAddr       = 5'd31;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // 0 = requester A has priority, 1 = requester B has priority
  logic ptr_q, ptr_d;

  // Grant decode and pointer advance to the loser of every grant.
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      if (req_i[0] && req_i[1]) begin
        gnt_o = ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt_o = req_i;
      end
    end
    if (gnt_o != 2'b00) begin
      ptr_d = gnt_o[0];
    end
  end

  // Pointer register, resets to A.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: clears registers 1..31 after reset, then
// merges ALU and load writebacks round-robin onto one registered write port.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          CLEAR_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_a_valid,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_data,
  output logic              o_a_ready,
  input  logic              i_b_valid,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_data,
  output logic              o_b_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_init_done
);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        gnt;

  rr_arb2 u_rr_arb2 (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .en_i   (state_q == StRun),
    .req_i  ({i_b_valid, i_a_valid}),
    .gnt_o  (gnt)
  );

  // Next-state, clear sequencing and write-port selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StClear: begin
        if (CLEAR_EN) begin
          we_d    = 1'b1;
          waddr_d = ADDR_W'(cnt_q);
          wdata_d = '0;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == LastAddr) begin
            state_d = StRun;
          end
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        // Writes to the zero register complete the handshake but are dropped.
        if (gnt[0]) begin
          we_d    = (i_a_addr != ADDR_W'(ZeroAddr));
          waddr_d = i_a_addr;
          wdata_d = i_a_data;
        end else if (gnt[1]) begin
          we_d    = (i_b_addr != ADDR_W'(ZeroAddr));
          waddr_d = i_b_addr;
          wdata_d = i_b_data;
        end
      end
    endcase
  end

  // State and write-port registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StClear;
      cnt_q   <= FirstClearAddr;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_a_ready   = gnt[0];
  assign o_b_ready   = gnt[1];
  assign o_we        = we_q;
  assign o_waddr     = waddr_q;
  assign o_wdata     = wdata_q;
  assign o_init_done = (state_q == StRun);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with default parameters.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, we, init_done;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] rf [32];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_a_valid   (a_valid),
    .i_a_addr    (a_addr),
    .i_a_data    (a_data),
    .o_a_ready   (a_ready),
    .i_b_valid   (b_valid),
    .i_b_addr    (b_addr),
    .i_b_data    (b_data),
    .o_b_ready   (b_ready),
    .o_we        (we),
    .o_waddr     (waddr),
    .o_wdata     (wdata),
    .o_init_done (init_done)
  );

  // Behavioural register file fed by the write port.
  always @(posedge clk) if (we) rf[waddr] <= wdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h2;
    repeat (3) step();
    chk("reset we", {31'd0, we}, 32'd0);
    chk("reset waddr", {27'd0, waddr}, 32'd0);
    chk("reset wdata", wdata, 32'd0);
    chk("reset init_done", {31'd0, init_done}, 32'd0);
    chk("reset a_ready", {31'd0, a_ready}, 32'd0);
    chk("reset b_ready", {31'd0, b_ready}, 32'd0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_clear();
    for (int i = 1; i <= 31; i++) begin
      step();
      chk($sformatf("clear we %0d", i), {31'd0, we}, 32'd1);
      chk($sformatf("clear waddr %0d", i), {27'd0, waddr}, i);
      chk($sformatf("clear wdata %0d", i), wdata, 32'd0);
      if (i < 31) chk($sformatf("clear init_done %0d", i), {31'd0, init_done}, 32'd0);
    end
    chk("clear done", {31'd0, init_done}, 32'd1);
    step();
    chk("clear idle we", {31'd0, we}, 32'd0);
    chk("clear idle init_done", {31'd0, init_done}, 32'd1);
  endtask

  task automatic test_a_only();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h12345678;
    #1;
    chk("a_only a_ready", {31'd0, a_ready}, 32'd1);
    chk("a_only b_ready", {31'd0, b_ready}, 32'd0);
    step();
    a_valid = 1'b0;
    chk("a_only we", {31'd0, we}, 32'd1);
    chk("a_only waddr", {27'd0, waddr}, 32'd5);
    chk("a_only wdata", wdata, 32'h12345678);
  endtask

  task automatic test_b_addr0();
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
    #1;
    chk("addr0 b_ready", {31'd0, b_ready}, 32'd1);
    chk("addr0 a_ready", {31'd0, a_ready}, 32'd0);
    step();
    b_valid = 1'b0;
    chk("addr0 we", {31'd0, we}, 32'd0);
  endtask

  task automatic test_back_to_back();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hA;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'hB;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("b2b a_ready %0d", k), {31'd0, a_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("b2b b_ready %0d", k), {31'd0, b_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      step();
      chk($sformatf("b2b we %0d", k), {31'd0, we}, 32'd1);
      chk($sformatf("b2b waddr %0d", k), {27'd0, waddr}, (k % 2 == 0) ? 32'd3 : 32'd4);
      chk($sformatf("b2b wdata %0d", k), wdata, (k % 2 == 0) ? 32'hA : 32'hB);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();
    chk("idle we", {31'd0, we}, 32'd0);
    chk("idle waddr hold", {27'd0, waddr}, 32'd4);
    chk("idle wdata hold", wdata, 32'hB);
  endtask

  task automatic test_same_addr();
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h2;
    #1;
    chk("same a_ready", {31'd0, a_ready}, 32'd1);
    chk("same b_ready hold", {31'd0, b_ready}, 32'd0);
    step();
    a_valid = 1'b0;
    chk("same first waddr", {27'd0, waddr}, 32'd7);
    chk("same first wdata", wdata, 32'h1);
    #1;
    chk("same b_ready", {31'd0, b_ready}, 32'd1);
    step();
    b_valid = 1'b0;
    chk("same second waddr", {27'd0, waddr}, 32'd7);
    chk("same second wdata", wdata, 32'h2);
    step();
    chk("same readback r7", rf[7], 32'h2);
  endtask

  task automatic test_reset_mid_clear();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) step();
    chk("mid pre waddr", {27'd0, waddr}, 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst we", {31'd0, we}, 32'd0);
    chk("mid rst waddr", {27'd0, waddr}, 32'd0);
    chk("mid rst init_done", {31'd0, init_done}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid restart we", {31'd0, we}, 32'd1);
    chk("mid restart waddr", {27'd0, waddr}, 32'd1);
    chk("mid restart wdata", wdata, 32'd0);
    repeat (30) step();
    chk("mid restart last waddr", {27'd0, waddr}, 32'd31);
    chk("mid restart done", {31'd0, init_done}, 32'd1);
  endtask

  initial begin
    #2;
    test_reset();
    test_clear();
    test_a_only();
    test_b_addr0();
    test_back_to_back();
    test_same_addr();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
